// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and widths for the ALU scheduler
package alu_sched_pkg;

    localparam int OP_W    = 3;
    localparam int NUM_REQ = 2;
    // Wide enough for EXEC_CYCLES up to 15.
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rtl/alu_sched_rr_arb2.sv - two-requester round-robin grant selection
// Ports:
//   valid      - request valid per requester
//   last_grant - index of the requester served most recently
//   gnt_onehot - one-hot grant, all zero when nothing is valid
//   gnt_idx    - index of the granted requester (0 when nothing is valid)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt_onehot,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx    = 1'b0;
        gnt_onehot = 2'b00;
        // On a tie the requester that was not served last wins.
        if (valid == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (valid[1]) begin
            gnt_idx = 1'b1;
        end
        if (|valid) begin
            gnt_onehot = gnt_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester ALU operation scheduler (IDLE/EXEC/RESP)
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid, req_op   - per-requester request and packed opcodes {op1, op0}
//   req_ready           - accept strobe to the granted requester
//   src_sel, op_sel     - operand mux select and ALU opcode
//   ld_a, ld_b, ld_r    - operand A/B and result register load enables
//   resp_valid, resp_id - completed result and its owner
//   resp_ready          - consumer takes the result
//   busy                - scheduler not idle
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    src_sel,
    output logic [OP_W-1:0]         op_sel,
    output logic                    ld_a,
    output logic                    ld_b,
    output logic                    ld_r,
    output logic                    resp_valid,
    output logic                    resp_id,
    input  logic                    resp_ready,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  op_q;
    logic             g_q;
    logic             last_grant;
    logic [1:0]       gnt_onehot;
    logic             gnt_idx;
    logic             accept;
    logic             done;

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign op_sel = op_q;

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        src_sel    = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_r       = 1'b0;
        resp_valid = 1'b0;
        resp_id    = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Accept and operand load happen on the same edge.
                if (|req_valid) begin
                    req_ready = gnt_onehot;
                    src_sel   = gnt_idx;
                    ld_a      = 1'b1;
                    ld_b      = 1'b1;
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    ld_r      = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                resp_id    = g_q;
                if (resp_ready) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Outputs are quiet for the whole reset cycle, not just after the edge.
        if (rst) begin
            req_ready  = '0;
            src_sel    = 1'b0;
            ld_a       = 1'b0;
            ld_b       = 1'b0;
            ld_r       = 1'b0;
            resp_valid = 1'b0;
            resp_id    = 1'b0;
            busy       = 1'b0;
            accept     = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            g_q        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= gnt_idx ? req_op[OP_W +: OP_W] : req_op[0 +: OP_W];
                g_q  <= gnt_idx;
                cnt  <= '0;
            end else if (state == ST_EXEC) begin
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                last_grant <= g_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched (EXEC_CYCLES 1 and 4)
module tb_alu_sched;

    localparam int EC_A = 1;
    localparam int EC_B = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [5:0] req_op = '0;
    logic       resp_ready = 1'b0;

    logic [1:0] req_ready_1, req_ready_4;
    logic       src_sel_1, src_sel_4;
    logic [2:0] op_sel_1, op_sel_4;
    logic       ld_a_1, ld_a_4, ld_b_1, ld_b_4, ld_r_1, ld_r_4;
    logic       resp_valid_1, resp_valid_4, resp_id_1, resp_id_4, busy_1, busy_4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sched #(.EXEC_CYCLES(EC_A)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready_1), .src_sel(src_sel_1), .op_sel(op_sel_1),
        .ld_a(ld_a_1), .ld_b(ld_b_1), .ld_r(ld_r_1), .resp_valid(resp_valid_1),
        .resp_id(resp_id_1), .resp_ready(resp_ready), .busy(busy_1)
    );

    alu_sched #(.EXEC_CYCLES(EC_B)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready_4), .src_sel(src_sel_4), .op_sel(op_sel_4),
        .ld_a(ld_a_4), .ld_b(ld_b_4), .ld_r(ld_r_4), .resp_valid(resp_valid_4),
        .resp_id(resp_id_4), .resp_ready(resp_ready), .busy(busy_4)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_op = '0; resp_ready = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; req_op = 6'o77; resp_ready = 1'b1;
        nxt();
        checks++;
        if ({req_ready_1, ld_a_1, ld_b_1, ld_r_1, resp_valid_1, busy_1, src_sel_1, resp_id_1} !== 9'd0) begin
            errors++; $display("FAIL reset_outs_1 got %b exp 0",
                {req_ready_1, ld_a_1, ld_b_1, ld_r_1, resp_valid_1, busy_1, src_sel_1, resp_id_1});
        end
        checks++;
        if ({req_ready_4, ld_a_4, ld_b_4, ld_r_4, resp_valid_4, busy_4, src_sel_4, resp_id_4} !== 9'd0) begin
            errors++; $display("FAIL reset_outs_4 got %b exp 0",
                {req_ready_4, ld_a_4, ld_b_4, ld_r_4, resp_valid_4, busy_4, src_sel_4, resp_id_4});
        end
        checks++;
        if ({op_sel_1, op_sel_4} !== 6'd0) begin
            errors++; $display("FAIL reset_op_sel got %o exp 0", {op_sel_1, op_sel_4});
        end
    endtask

    task automatic test_basic();
        do_reset();
        req_valid = 2'b01; req_op = 6'b000_010;
        #1;
        checks++;
        if ({req_ready_1, ld_a_1, ld_b_1, src_sel_1, ld_r_1, busy_1} !== 7'b01_1_1_0_0_0) begin
            errors++; $display("FAIL basic_accept got %b exp 0111000",
                {req_ready_1, ld_a_1, ld_b_1, src_sel_1, ld_r_1, busy_1});
        end
        nxt();
        req_valid = '0; req_op = '0;
        #1;
        checks++;
        if ({ld_r_1, resp_valid_1, busy_1, req_ready_1, op_sel_1} !== 8'b1_0_1_00_010) begin
            errors++; $display("FAIL basic_exec got %b exp 10100010",
                {ld_r_1, resp_valid_1, busy_1, req_ready_1, op_sel_1});
        end
        nxt();
        checks++;
        if ({resp_valid_1, resp_id_1, ld_r_1, busy_1, op_sel_1} !== 7'b1_0_0_1_010) begin
            errors++; $display("FAIL basic_resp got %b exp 1001010",
                {resp_valid_1, resp_id_1, ld_r_1, busy_1, op_sel_1});
        end
        resp_ready = 1'b1;
        nxt();
        resp_ready = 1'b0;
        #1;
        checks++;
        if ({busy_1, resp_valid_1, op_sel_1} !== 5'b0_0_010) begin
            errors++; $display("FAIL basic_release got %b exp 00010", {busy_1, resp_valid_1, op_sel_1});
        end
    endtask

    task automatic test_round_robin();
        int acc[$];
        int gr[$];
        int pend_op;
        do_reset();
        req_valid = 2'b11; resp_ready = 1'b1;
        pend_op = -1;
        for (int c = 0; c < 30 && acc.size() < 4; c++) begin
            req_op = 6'($urandom);
            #1;
            if (pend_op >= 0) begin
                checks++;
                if (int'(op_sel_1) !== pend_op) begin
                    errors++; $display("FAIL rr_op_sel cycle %0d got %0d exp %0d", c, op_sel_1, pend_op);
                end
                pend_op = -1;
            end
            if (req_ready_1 != 2'b00) begin
                acc.push_back(c);
                gr.push_back(int'(req_ready_1 == 2'b10));
                pend_op = (req_ready_1 == 2'b10) ? int'(req_op[5:3]) : int'(req_op[2:0]);
            end
            nxt();
        end
        checks++;
        if (acc.size() != 4) begin
            errors++; $display("FAIL rr_accept_count got %0d exp 4", acc.size());
        end
        for (int i = 0; i < acc.size(); i++) begin
            checks++;
            if (gr[i] !== (i % 2)) begin
                errors++; $display("FAIL rr_grant %0d got %0d exp %0d", i, gr[i], i % 2);
            end
            if (i > 0) begin
                checks++;
                if (acc[i] - acc[i-1] !== EC_A + 2) begin
                    errors++; $display("FAIL rr_spacing %0d got %0d exp %0d", i, acc[i] - acc[i-1], EC_A + 2);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 2'b10; req_op = 6'b101_000; resp_ready = 1'b0;
        #1;
        checks++;
        if ({req_ready_1, src_sel_1} !== 3'b10_1) begin
            errors++; $display("FAIL bp_accept got %b exp 101", {req_ready_1, src_sel_1});
        end
        nxt();
        req_valid = '0;
        nxt();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({resp_valid_1, busy_1, req_ready_1, resp_id_1, op_sel_1} !== 8'b1_1_00_1_101) begin
                errors++; $display("FAIL bp_hold %0d got %b exp 11001101", i,
                    {resp_valid_1, busy_1, req_ready_1, resp_id_1, op_sel_1});
            end
            nxt();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({resp_valid_1, req_ready_1} !== 3'b1_00) begin
            errors++; $display("FAIL bp_release got %b exp 100", {resp_valid_1, req_ready_1});
        end
        nxt();
        resp_ready = 1'b0;
        #1;
        checks++;
        if ({busy_1, resp_valid_1, req_ready_1, src_sel_1} !== 5'b0_0_01_0) begin
            errors++; $display("FAIL bp_next_grant got %b exp 00010",
                {busy_1, resp_valid_1, req_ready_1, src_sel_1});
        end
        req_valid = '0;
    endtask

    task automatic test_exec4();
        int ldr_cnt = 0;
        int ldr_at = -1;
        int rv_at = -1;
        do_reset();
        req_valid = 2'b10; req_op = 6'b011_000; resp_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c == 0) begin
                checks++;
                if (req_ready_4 !== 2'b10) begin
                    errors++; $display("FAIL ex4_accept got %b exp 10", req_ready_4);
                end
            end
            if (ld_r_4) begin
                ldr_cnt++;
                if (ldr_at < 0) ldr_at = c;
            end
            if (resp_valid_4 && rv_at < 0) rv_at = c;
            nxt();
            req_valid = '0;
        end
        checks++;
        if (ldr_cnt !== 1 || ldr_at !== EC_B) begin
            errors++; $display("FAIL ex4_ld_r got count %0d at %0d exp count 1 at %0d", ldr_cnt, ldr_at, EC_B);
        end
        checks++;
        if (rv_at !== EC_B + 1) begin
            errors++; $display("FAIL ex4_resp_valid got %0d exp %0d", rv_at, EC_B + 1);
        end
        checks++;
        if ({resp_id_4, op_sel_4} !== 4'b1_011) begin
            errors++; $display("FAIL ex4_owner got %b exp 1011", {resp_id_4, op_sel_4});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 2'b01; req_op = 6'($urandom); resp_ready = 1'b1;
        nxt();
        req_valid = '0;
        nxt();
        rst = 1'b1; req_valid = 2'b11;
        #1;
        checks++;
        if ({req_ready_4, ld_a_4, ld_b_4, ld_r_4, resp_valid_4, busy_4, src_sel_4, resp_id_4} !== 9'd0) begin
            errors++; $display("FAIL midrst_outs got %b exp 0",
                {req_ready_4, ld_a_4, ld_b_4, ld_r_4, resp_valid_4, busy_4, src_sel_4, resp_id_4});
        end
        nxt();
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready_4, busy_4, resp_valid_4, op_sel_4} !== 7'b01_0_0_000) begin
            errors++; $display("FAIL midrst_regrant got %b exp 0100000",
                {req_ready_4, busy_4, resp_valid_4, op_sel_4});
        end
        nxt();
        req_valid = '0;
        for (int c = 1; c <= EC_B; c++) begin
            #1;
            checks++;
            if ({resp_valid_4, ld_r_4} !== {1'b0, c == EC_B}) begin
                errors++; $display("FAIL midrst_quiet cycle %0d got %b exp %b", c,
                    {resp_valid_4, ld_r_4}, {1'b0, c == EC_B});
            end
            nxt();
        end
    endtask

    // Transaction-level model: after an accept at cycle A the owner sees ld_r
    // at A+ec and a pending response from A+ec+1 until it is taken.
    task automatic test_random(input int ec, input int n);
        bit         m_busy = 1'b0;
        bit         m_last = 1'b1;
        bit         own = 1'b0;
        bit         g;
        int         acc = 0;
        int         k;
        logic [2:0] m_op = '0;
        logic [6:0] exp_v, obs_v;
        bit         e_ld, e_ldr, e_rv, e_busy, accepted, released;
        logic [1:0] e_rdy;
        do_reset();
        for (int c = 0; c < n; c++) begin
            req_valid  = 2'($urandom);
            req_op     = 6'($urandom);
            resp_ready = ($urandom % 3) != 0;
            #1;
            e_rdy = '0; e_ld = 0; e_ldr = 0; e_rv = 0; e_busy = 0;
            accepted = 0; released = 0; g = 0;
            if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    g = (req_valid == 2'b11) ? !m_last : req_valid[1];
                    e_rdy = g ? 2'b10 : 2'b01;
                    e_ld = 1;
                    accepted = 1;
                end
            end else begin
                k = c - acc;
                e_busy = 1;
                e_ldr = (k == ec);
                e_rv = (k > ec);
                released = e_rv && resp_ready;
            end
            exp_v = {e_rdy, e_ld, e_ld, e_ldr, e_rv, e_busy};
            obs_v = (ec == EC_A) ? {req_ready_1, ld_a_1, ld_b_1, ld_r_1, resp_valid_1, busy_1}
                                 : {req_ready_4, ld_a_4, ld_b_4, ld_r_4, resp_valid_4, busy_4};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rand_ec%0d_ctrl cycle %0d got %b exp %b", ec, c, obs_v, exp_v);
            end
            checks++;
            if (((ec == EC_A) ? op_sel_1 : op_sel_4) !== m_op) begin
                errors++; $display("FAIL rand_ec%0d_op_sel cycle %0d got %0d exp %0d", ec, c,
                    (ec == EC_A) ? op_sel_1 : op_sel_4, m_op);
            end
            if (accepted) begin
                checks++;
                if (((ec == EC_A) ? src_sel_1 : src_sel_4) !== g) begin
                    errors++; $display("FAIL rand_ec%0d_src_sel cycle %0d got %0d exp %0d", ec, c,
                        (ec == EC_A) ? src_sel_1 : src_sel_4, g);
                end
            end
            if (e_rv) begin
                checks++;
                if (((ec == EC_A) ? resp_id_1 : resp_id_4) !== own) begin
                    errors++; $display("FAIL rand_ec%0d_resp_id cycle %0d got %0d exp %0d", ec, c,
                        (ec == EC_A) ? resp_id_1 : resp_id_4, own);
                end
            end
            if (accepted) begin
                m_busy = 1; acc = c; own = g;
                m_op = g ? req_op[5:3] : req_op[2:0];
            end
            if (released) begin
                m_busy = 0; m_last = own;
            end
            nxt();
        end
        req_valid = '0; resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_exec4();
        test_reset_mid();
        test_random(EC_A, 300);
        test_random(EC_B, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning the number of cycles from operand load to result load (legal range 1..15).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-005 SHALL have port req_op  input  6  packed opcodes, {op1[2:0], op0[2:0]}.
REQ-006 SHALL have port req_ready  output  2  per-requester accept, at most one bit high.
REQ-007 SHALL have port src_sel  output  1  operand mux select to the datapath (index of the granted requester).
REQ-008 SHALL have port op_sel  output  3  opcode driven to the ALU.
REQ-009 SHALL have port ld_a  output  1  load enable for operand register A.
REQ-010 SHALL have port ld_b  output  1  load enable for operand register B.
REQ-011 SHALL have port ld_r  output  1  load enable for result register.
REQ-012 SHALL have port resp_valid  output  1  result register holds a completed result.
REQ-013 SHALL have port resp_id  output  1  requester index that owns the current result.
REQ-014 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-017 In IDLE, SHALL select grant g by round-robin: if only one requester is valid, grant it; if both are valid, grant the requester other than last_grant.
REQ-018 In IDLE with any requester valid, SHALL drive req_ready[g]=1, ld_a=ld_b=1 and src_sel=g combinationally in that cycle, so accept and operand load occur at the same edge.
REQ-019 On accept, SHALL latch op from req_op for requester g into op_sel, latch g, clear the cycle counter and go to EXEC.
REQ-020 SHALL hold op_sel constant from accept until the next accept.
REQ-021 In EXEC, SHALL increment the counter each cycle and assert ld_r for exactly one cycle, the cycle in which counter == EXEC_CYCLES-1, then go to RESP.
REQ-022 In RESP, SHALL drive resp_valid=1 and resp_id=latched g, and hold both until resp_ready=1.
REQ-023 When resp_valid && resp_ready, SHALL set last_grant=g and return to IDLE.
REQ-024 SHALL drive req_ready=0, ld_a=0 and ld_b=0 in EXEC and RESP; new requests are never accepted while busy.
REQ-025 Latency: accept at edge T; ld_r high in cycle T+EXEC_CYCLES; resp_valid high from cycle T+EXEC_CYCLES+1.
REQ-026 Minimum accept-to-accept spacing SHALL be EXEC_CYCLES+2 cycles.
REQ-027 A req_valid that drops before being granted SHALL have no effect.
REQ-028 resp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-029 With rst=1 at a clock edge, SHALL enter IDLE with last_grant=1, counter=0, op_sel=0 and latched g=0, so requester 0 wins the first tie.
REQ-030 While rst=1, SHALL force req_ready, ld_a, ld_b, ld_r, resp_valid, busy, src_sel and resp_id to 0.
REQ-031 Reset mid-operation SHALL abandon the transaction; no ld_r and no resp_valid are produced for it.

Structure
REQ-032 SHALL place the state enum, OP_W=3 and NUM_REQ=2 in shared package alu_sched_pkg.
REQ-033 SHALL factor the grant logic into sub-module rr_arb2 with inputs valid[1:0] and last_grant, and outputs gnt_onehot[1:0] and gnt_idx.

Verification
REQ-034 After reset with EXEC_CYCLES=1, req_valid=01 and op0=010: req_ready=01, ld_a=ld_b=1 and src_sel=0 in cycle 0; ld_r=1 in cycle 1; resp_valid=1 with resp_id=0 in cycle 2; op_sel=010 throughout.
REQ-035 With req_valid=11 held and resp_ready=1: grants SHALL go 0,1,0,1 across four transactions, with accepts exactly 3 cycles apart.
REQ-036 With resp_ready held 0 for 5 cycles in RESP: resp_valid and busy stay 1, req_ready stays 00, and release occurs on the cycle resp_ready=1.
REQ-037 With EXEC_CYCLES=4: ld_r SHALL pulse once, 4 cycles after accept, and resp_valid SHALL rise 5 cycles after accept.
REQ-038 With rst=1 in the second EXEC cycle and req_valid=11 after release: no resp_valid appears, all outputs read 0, and the next grant is requester 0.
REQ-039 With req1 alone served first and then req_valid=11: the next grant SHALL be requester 0.
